hsync_timing_gen: RTL and testbench

Horizontal video timing generator. It sits directly upstream of the vertical sync stage and drives that stage's LineEnd input. It divides the system clock down to a pixel rate, then walks each line through Active Video, Back Porch, Synch Pulse and Front Porch. Along the way it produces hsync, the x coordinate, an active-video flag and a one-clock LineEnd pulse per line.

---
 rtl/hsync_timing_gen_if.sv | 36 +++
 rtl/hsync_timing_gen.sv | 119 +++++++++++
 tb/tb_hsync_timing_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hsync_timing_gen_if.sv
// hsync_timing_gen_if
// Purpose : bundles the horizontal timing generator's configuration inputs
//           and timing outputs so they can be passed around as one port.
// Signals : SynchPulse, BackPorch, ActiveVideo, FrontPorch - phase lengths
//           in pixels (sampled by the generator at reset and at LineEnd).
//           hsync, LineEnd, PixelTick, HActive, xposition - timing outputs.
//           state_dbg - current phase, for observation only.
// Modports: master = the timing generator, slave = the configuring /
//           consuming side.
// Handshake: there is no valid/ready pair here. Lengths are static levels
//           captured on LineEnd; LineEnd and PixelTick are single-clock
//           strobes that a consumer acts on in the cycle they are high.
interface hsync_timing_gen_if #(
  parameter int xresolution = 10
);
  logic [xresolution-1:0] SynchPulse;
  logic [xresolution-1:0] BackPorch;
  logic [xresolution-1:0] ActiveVideo;
  logic [xresolution-1:0] FrontPorch;
  logic                   hsync;
  logic                   LineEnd;
  logic                   PixelTick;
  logic                   HActive;
  logic [xresolution-1:0] xposition;
  logic [1:0]             state_dbg;

  modport master (
    input  SynchPulse, BackPorch, ActiveVideo, FrontPorch,
    output hsync, LineEnd, PixelTick, HActive, xposition, state_dbg
  );

  modport slave (
    output SynchPulse, BackPorch, ActiveVideo, FrontPorch,
    input  hsync, LineEnd, PixelTick, HActive, xposition, state_dbg
  );
endinterface

// File: rtl/hsync_timing_gen.sv
// hsync_timing_gen
// Purpose : horizontal video timing generator. Divides the system clock to a
//           pixel rate and walks each line through ACTIVE -> BACK -> SYNC ->
//           FRONT, producing hsync, xposition, HActive and a one-clock
//           LineEnd pulse that the vertical stage can use as an increment.
// Ports   : clock - system clock, rising edge.
//           reset - synchronous, active-low.
//           bus   - hsync_timing_gen_if.master (lengths in, timing out).
module hsync_timing_gen #(
  parameter int xresolution = 10,
  parameter int CLKDIV      = 4,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  hsync_timing_gen_if.master    bus
);

  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_BACK   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_FRONT  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [xresolution-1:0] r_pcount;
  logic [xresolution-1:0] w_pcount_next;
  logic [DIVW-1:0]        r_div;
  logic [xresolution-1:0] r_len_a;
  logic [xresolution-1:0] r_len_b;
  logic [xresolution-1:0] r_len_s;
  logic [xresolution-1:0] r_len_f;
  logic [xresolution-1:0] w_len_last;
  logic                   w_tick;
  logic                   w_phase_last;
  logic                   w_line_end;

  // Index of the last pixel of a phase; a zero length behaves as one pixel
  // so no phase is ever skipped.
  function automatic logic [xresolution-1:0] last_idx(input logic [xresolution-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  // Tick and LineEnd are gated by reset so they are forced low in reset.
  assign w_tick       = reset & (r_div == DIV_LAST);
  assign w_phase_last = (r_pcount == w_len_last);
  assign w_line_end   = w_tick & (r_state == ST_FRONT) & w_phase_last;

  always_comb begin
    w_len_last = last_idx(r_len_a);
    unique case (r_state)
      ST_ACTIVE: w_len_last = last_idx(r_len_a);
      ST_BACK:   w_len_last = last_idx(r_len_b);
      ST_SYNC:   w_len_last = last_idx(r_len_s);
      ST_FRONT:  w_len_last = last_idx(r_len_f);
      default:   w_len_last = last_idx(r_len_a);
    endcase
  end

  // State register. Shadow lengths reload at reset and at LineEnd so that
  // a mid-line change of the inputs only affects the following line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div    <= '0;
      r_state  <= ST_ACTIVE;
      r_pcount <= '0;
      r_len_a  <= bus.ActiveVideo;
      r_len_b  <= bus.BackPorch;
      r_len_s  <= bus.SynchPulse;
      r_len_f  <= bus.FrontPorch;
    end else begin
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_state  <= w_state_next;
      r_pcount <= w_pcount_next;
      if (w_line_end) begin
        r_len_a <= bus.ActiveVideo;
        r_len_b <= bus.BackPorch;
        r_len_s <= bus.SynchPulse;
        r_len_f <= bus.FrontPorch;
      end
    end
  end

  // Next-state logic: everything advances only on a pixel tick.
  always_comb begin
    w_state_next  = r_state;
    w_pcount_next = r_pcount;
    if (w_tick) begin
      if (w_phase_last) begin
        w_pcount_next = '0;
        unique case (r_state)
          ST_ACTIVE: w_state_next = ST_BACK;
          ST_BACK:   w_state_next = ST_SYNC;
          ST_SYNC:   w_state_next = ST_FRONT;
          ST_FRONT:  w_state_next = ST_ACTIVE;
          default:   w_state_next = ST_ACTIVE;
        endcase
      end else begin
        w_pcount_next = r_pcount + 1'b1;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    bus.HActive   = (r_state == ST_ACTIVE);
    bus.xposition = (r_state == ST_ACTIVE) ? r_pcount : '0;
    bus.hsync     = (r_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    bus.LineEnd   = w_line_end;
    bus.PixelTick = w_tick;
    bus.state_dbg = r_state;
  end

endmodule

// File: tb/tb_hsync_timing_gen.sv
// tb_hsync_timing_gen
// Purpose : self-checking bench for hsync_timing_gen. Three instances share
//           one clock and reset: CLKDIV=1/active-low sync, CLKDIV=4/active-low
//           sync and CLKDIV=4/active-high sync with VGA 640x480 lengths.
module tb_hsync_timing_gen;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hsync_timing_gen_if #(.xresolution(10)) if1 ();
  hsync_timing_gen_if #(.xresolution(10)) if4 ();
  hsync_timing_gen_if #(.xresolution(10)) ifv ();

  hsync_timing_gen #(.xresolution(10), .CLKDIV(1), .SYNC_POL(1'b0)) dut1 (
    .clock(clock), .reset(reset), .bus(if1));
  hsync_timing_gen #(.xresolution(10), .CLKDIV(4), .SYNC_POL(1'b0)) dut4 (
    .clock(clock), .reset(reset), .bus(if4));
  hsync_timing_gen #(.xresolution(10), .CLKDIV(4), .SYNC_POL(1'b1)) dutv (
    .clock(clock), .reset(reset), .bus(ifv));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One CLKDIV=1 line with A=4 B=2 S=3 F=1, indexed by clock within the line.
  typedef struct {
    int xpos;
    int hact;
    int hs;
    int le;
  } vec_t;
  vec_t tbl[10];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at the sample point of clock 0 of a fresh line.
  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic set_len1(input int a, input int b, input int s, input int f);
    if1.ActiveVideo = 10'(a);
    if1.BackPorch   = 10'(b);
    if1.SynchPulse  = 10'(s);
    if1.FrontPorch  = 10'(f);
  endtask

  task automatic run_table(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      vec_t v;
      v = tbl[c % 10];
      check($sformatf("%s c%0d xposition", tag, c), int'(if1.xposition), v.xpos);
      check($sformatf("%s c%0d HActive", tag, c), int'(if1.HActive), v.hact);
      check($sformatf("%s c%0d hsync", tag, c), int'(if1.hsync), v.hs);
      check($sformatf("%s c%0d LineEnd", tag, c), int'(if1.LineEnd), v.le);
      check($sformatf("%s c%0d PixelTick", tag, c), int'(if1.PixelTick), 1);
      step();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int hs_hi, first_hi, last_hi, le_cnt, le_first, le_second, xmax, hact_cnt;

    tbl[0] = '{0, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{2, 1, 1, 0};
    tbl[3] = '{3, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 0};
    tbl[5] = '{0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0};
    tbl[9] = '{0, 0, 1, 1};

    set_len1(4, 2, 3, 1);
    if4.ActiveVideo = 10'd4;   if4.BackPorch = 10'd2;
    if4.SynchPulse  = 10'd3;   if4.FrontPorch = 10'd1;
    ifv.ActiveVideo = 10'd640; ifv.BackPorch = 10'd48;
    ifv.SynchPulse  = 10'd96;  ifv.FrontPorch = 10'd16;

    // Reset state, sampled while reset is still low.
    reset = 1'b0;
    step();
    step();
    check("rst hsync1", int'(if1.hsync), 1);
    check("rst HActive1", int'(if1.HActive), 1);
    check("rst xposition1", int'(if1.xposition), 0);
    check("rst LineEnd1", int'(if1.LineEnd), 0);
    check("rst PixelTick1", int'(if1.PixelTick), 0);
    check("rst state1", int'(if1.state_dbg), 0);
    check("rst PixelTick4", int'(if4.PixelTick), 0);
    check("rst hsyncv", int'(ifv.hsync), 0);
    reset = 1'b1;
    #1;

    // Basic CLKDIV=1 line, two periods.
    run_table("basic", 20);

    // CLKDIV=4: tick every 4th clock, LineEnd every 40, hsync low 24..35.
    do_reset();
    for (int c = 0; c < 80; c++) begin
      check($sformatf("div4 c%0d PixelTick", c), int'(if4.PixelTick), int'(c % 4 == 3));
      check($sformatf("div4 c%0d LineEnd", c), int'(if4.LineEnd), int'(c % 40 == 39));
      check($sformatf("div4 c%0d hsync", c), int'(if4.hsync),
            int'(!((c % 40) >= 24 && (c % 40) <= 35)));
      step();
    end

    // Mid-line change of ActiveVideo takes effect on the next line.
    set_len1(4, 2, 3, 1);
    do_reset();
    for (int c = 0; c < 26; c++) begin
      check($sformatf("shadow c%0d LineEnd", c), int'(if1.LineEnd), int'(c == 9 || c == 21));
      if (c == 15) begin
        check("shadow c15 xposition", int'(if1.xposition), 5);
        check("shadow c15 HActive", int'(if1.HActive), 1);
      end
      if (c == 16) check("shadow c16 HActive", int'(if1.HActive), 0);
      if (c == 2) if1.ActiveVideo = 10'd6;
      step();
    end

    // Zero-length sync and front porch behave as one pixel each.
    set_len1(4, 2, 0, 0);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      check($sformatf("zero c%0d hsync", c), int'(if1.hsync), int'(c % 8 != 6));
      check($sformatf("zero c%0d LineEnd", c), int'(if1.LineEnd), int'(c % 8 == 7));
      check($sformatf("zero c%0d HActive", c), int'(if1.HActive), int'(c % 8 < 4));
      step();
    end

    // Reset pulse during SYNC aborts the line; a full line follows.
    set_len1(4, 2, 3, 1);
    do_reset();
    for (int c = 0; c < 7; c++) step();
    check("midrst pre hsync", int'(if1.hsync), 0);
    reset = 1'b0;
    step();
    check("midrst hsync", int'(if1.hsync), 1);
    check("midrst HActive", int'(if1.HActive), 1);
    check("midrst xposition", int'(if1.xposition), 0);
    check("midrst LineEnd", int'(if1.LineEnd), 0);
    check("midrst state", int'(if1.state_dbg), 0);
    reset = 1'b1;
    #1;
    run_table("postrst", 10);

    // VGA lengths, active-high sync, CLKDIV=4, two lines.
    do_reset();
    hs_hi = 0; first_hi = -1; last_hi = -1; le_cnt = 0;
    le_first = -1; le_second = -1; xmax = 0; hact_cnt = 0;
    for (int c = 0; c < 6400; c++) begin
      if (c < 3200) begin
        if (ifv.hsync) begin
          hs_hi++;
          if (first_hi < 0) first_hi = c;
          last_hi = c;
        end
        if (ifv.HActive) hact_cnt++;
        if (int'(ifv.xposition) > xmax) xmax = int'(ifv.xposition);
      end
      if (ifv.LineEnd) begin
        le_cnt++;
        if (le_first < 0) le_first = c;
        else if (le_second < 0) le_second = c;
      end
      step();
    end
    check("vga hsync high clocks", hs_hi, 384);
    check("vga hsync first high", first_hi, 2752);
    check("vga hsync last high", last_hi, 3135);
    check("vga HActive clocks", hact_cnt, 2560);
    check("vga xposition max", xmax, 639);
    check("vga LineEnd count", le_cnt, 2);
    check("vga LineEnd first", le_first, 3199);
    check("vga LineEnd second", le_second, 6399);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
